savestate_ddr_responder: RTL and testbench
==========================================

Name: savestate_ddr_responder

Overview:
- DDR-side responder for the savestate engine's toggle req/ack channel.
- Each request toggle becomes one 64-bit single-beat write or read on the DDRAM (Avalon-style) port, at an auto-incrementing word pointer inside a selectable savestate slot.
- Sits between the GB savestate engine and the shared DDRAM arbiter port. Provides read-back data and an echoing ack toggle.

Parameters:
- BASE_ADDR, 29'h0180_0000: DDRAM word address of slot 0 (64-bit words).
- SLOT_SHIFT, 15: log2 words per slot (32768 words = 256 KiB).
- SLOT_BITS, 2: slot select width (4 slots).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ss_start  in  1  pulse: restart word pointer at slot start
- ss_slot  in  SLOT_BITS  slot index, sampled on restart
- ddr_req  in  1  request toggle from engine
- ddr_wren  in  1  1=write, 0=read; valid when req toggles
- ddr_do  in  64  write data from engine
- ddr_di  out  64  read data to engine
- ddr_ack  out  1  ack toggle; equals ddr_req when idle
- overflow  out  1  sticky: pointer wrapped within slot
- ddram_busy  in  1  DDR waitrequest
- ddram_burstcnt  out  8  constant 1
- ddram_addr  out  29  word address
- ddram_rd  out  1  read strobe
- ddram_we  out  1  write strobe
- ddram_din  out  64  write data
- ddram_be  out  8  constant 8'hFF
- ddram_dout  in  64  read data
- ddram_dout_ready  in  1  read data valid

Behaviour:
- Reset values (reset_n low at clk edge):
  - state=IDLE; ddr_ack=0; internal req_seen=0.
  - ddr_di=0; ddram_rd=0; ddram_we=0; ddram_addr=BASE_ADDR; ddram_din=0.
  - ptr=0; slot=0; overflow=0; restart_pend=0.
- Pending request: ddr_req != req_seen. On acceptance, req_seen <= ddr_req.
- ddr_ack is a register. It toggles exactly once per completed transaction, so ack==req means done.
- Address: ddram_addr = BASE_ADDR + {slot, ptr} (word units), registered at issue.
- States:
  - IDLE:
    - If restart_pend, or ss_start this cycle: ptr<=0, slot<=ss_slot, clear restart_pend. The request check below still runs in the same cycle.
    - If a request is pending: latch ddr_wren and ddr_do, drive addr.
    - ddr_wren=1 -> WR_ISSUE with we=1, din=ddr_do.
    - ddr_wren=0 -> RD_ISSUE with rd=1.
  - WR_ISSUE:
    - Hold we, addr and din while ddram_busy.
    - First edge with ~ddram_busy: we<=0, ack<=~ack, ptr++, -> IDLE.
    - Write latency is 2 clocks from req toggle to ack toggle when busy=0.
  - RD_ISSUE:
    - Hold rd and addr while ddram_busy.
    - First edge with ~ddram_busy: rd<=0, -> RD_WAIT.
  - RD_WAIT:
    - On ddram_dout_ready: ddr_di<=ddram_dout, ack<=~ack, ptr++, -> IDLE.
    - ddr_di and the ack change in the same cycle.
    - ddr_di holds until the next read completes.
- ss_start outside IDLE sets restart_pend; it is applied on the next IDLE cycle. An in-flight transaction is never aborted.
- Pointer wrap: ptr is SLOT_SHIFT bits. Incrementing from all-ones wraps to 0 and sets overflow. The transaction completes normally; neighbouring slots are never touched.
- overflow clears only on reset or on an applied restart.
- ddram_dout_ready outside RD_WAIT is ignored, e.g. a stale read return after reset.
- Double toggle of ddr_req before ack is a protocol violation. It is indistinguishable from no request; no requirement.
- Only one transaction is outstanding at a time. ddram_rd/ddram_we are never both high.

Decomposition:
- Package savestate_pkg:
  - state enum (IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT)
  - DDRAM_AW=29, DDRAM_DW=64, BURST_1=8'd1, BE_ALL=8'hFF
  - slot-address helper function
- Single module. No sub-module is natural; the toggle detector is two flops.

Test Plan:
- Write sequence:
  - Stimulus: reset, ss_start with ss_slot=1, then 3 write toggles with data 64'h1111…, 64'h2222…, 64'h3333…; busy=0.
  - Required: we pulses at BASE+0x8000, +0x8001, +0x8002 with matching din; each ack toggles 2 clocks after its req.
- Read with waitrequest:
  - Stimulus: ss_start with slot=0, read toggle, busy high for 4 cycles, dout_ready 3 cycles after issue with 64'hDEADBEEF_CAFEF00D.
  - Required: rd held with addr=BASE for 5 cycles; ddr_di=64'hDEADBEEF_CAFEF00D and ack toggles in the same cycle.
- Wrap:
  - Stimulus: 32769 writes to slot 3.
  - Required: last write goes to BASE+0x18000; overflow=1 after the 32768th ack; no address ≥ BASE+0x20000.
- Deferred restart:
  - Stimulus: ss_start asserted during RD_WAIT.
  - Required: the read completes at ptr N and increments the pointer; the next request uses ptr 0.
- Reset mid-read:
  - Stimulus: reset_n low during RD_WAIT, then a late dout_ready.
  - Required: all outputs at reset values, ack=0, ddr_di unchanged (0), no state change.
- Engine loopback:
  - Stimulus: connect the GB savestate engine to this block plus a DDR model; save, corrupt the GB RAMs, then load.
  - Required: all 64 state words and all RAM bytes restored bit-exact.

Source files
------------

// File: rtl/savestate_pkg.sv
// Shared types and constants for the savestate DDRAM responder.
//   state_e    : responder FSM states
//   DDRAM_*    : DDRAM port geometry (64-bit words, 29-bit word address)
//   BURST_1    : single-beat burst count
//   BE_ALL     : all byte lanes enabled
//   slot_addr(): word address of {slot, ptr} relative to a base address
package savestate_pkg;

  localparam int unsigned DDRAM_AW = 29;
  localparam int unsigned DDRAM_DW = 64;
  localparam logic [7:0]  BURST_1  = 8'd1;
  localparam logic [7:0]  BE_ALL   = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StWrIssue,
    StRdIssue,
    StRdWait
  } state_e;

  // Slot index lands above the pointer bits, so slots never overlap.
  function automatic logic [DDRAM_AW-1:0] slot_addr(input logic [DDRAM_AW-1:0] base,
                                                    input logic [DDRAM_AW-1:0] slot,
                                                    input logic [DDRAM_AW-1:0] ptr,
                                                    input int unsigned         shift);
    return base + (slot << shift) + ptr;
  endfunction

endpackage

// File: rtl/savestate_ddr_responder.sv
// DDR-side responder for the savestate engine's toggle req/ack channel.
// Each toggle of ddr_req becomes one single-beat 64-bit DDRAM write or read at
// an auto-incrementing word pointer inside the selected savestate slot; ddr_ack
// toggles once when that transaction completes.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   ss_start, ss_slot   restart pointer at start of slot ss_slot
//   ddr_req, ddr_wren   request toggle and direction (1 = write)
//   ddr_do / ddr_di     write data from / read data to the engine
//   ddr_ack             ack toggle, equals ddr_req when idle
//   overflow            sticky, pointer wrapped within the slot
//   ddram_*             Avalon-style DDRAM master port
module savestate_ddr_responder
  import savestate_pkg::*;
#(
  parameter logic [DDRAM_AW-1:0] BASE_ADDR  = 29'h0180_0000,
  parameter int unsigned         SLOT_SHIFT = 15,
  parameter int unsigned         SLOT_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ss_start,
  input  logic [SLOT_BITS-1:0] ss_slot,
  input  logic                 ddr_req,
  input  logic                 ddr_wren,
  input  logic [DDRAM_DW-1:0]  ddr_do,
  output logic [DDRAM_DW-1:0]  ddr_di,
  output logic                 ddr_ack,
  output logic                 overflow,
  input  logic                 ddram_busy,
  output logic [7:0]           ddram_burstcnt,
  output logic [DDRAM_AW-1:0]  ddram_addr,
  output logic                 ddram_rd,
  output logic                 ddram_we,
  output logic [DDRAM_DW-1:0]  ddram_din,
  output logic [7:0]           ddram_be,
  input  logic [DDRAM_DW-1:0]  ddram_dout,
  input  logic                 ddram_dout_ready
);

  state_e                state_q, state_d;
  logic                  req_seen_q, req_seen_d;
  logic                  ack_q, ack_d;
  logic [DDRAM_DW-1:0]   di_q, di_d;
  logic                  rd_q, rd_d;
  logic                  we_q, we_d;
  logic [DDRAM_AW-1:0]   addr_q, addr_d;
  logic [DDRAM_DW-1:0]   din_q, din_d;
  logic [SLOT_SHIFT-1:0] ptr_q, ptr_d;
  logic [SLOT_BITS-1:0]  slot_q, slot_d;
  logic                  overflow_q, overflow_d;
  logic                  restart_pend_q, restart_pend_d;

  logic                  req_pending;
  logic                  restart_apply;
  logic [SLOT_SHIFT-1:0] eff_ptr;
  logic [SLOT_BITS-1:0]  eff_slot;
  logic                  eff_overflow;
  logic [SLOT_SHIFT-1:0] ptr_inc;
  logic                  ptr_wrap;

  assign req_pending   = (ddr_req != req_seen_q);
  // A restart is only applied while idle so an in-flight access is never disturbed.
  assign restart_apply = (state_q == StIdle) && (restart_pend_q || ss_start);
  // Restart and request acceptance may share a cycle; the request sees the new slot.
  assign eff_ptr       = restart_apply ? '0 : ptr_q;
  assign eff_slot      = restart_apply ? ss_slot : slot_q;
  assign eff_overflow  = restart_apply ? 1'b0 : overflow_q;
  assign ptr_inc       = ptr_q + SLOT_SHIFT'(1);
  assign ptr_wrap      = &ptr_q;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      req_seen_q     <= 1'b0;
      ack_q          <= 1'b0;
      di_q           <= '0;
      rd_q           <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= BASE_ADDR;
      din_q          <= '0;
      ptr_q          <= '0;
      slot_q         <= '0;
      overflow_q     <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_seen_q     <= req_seen_d;
      ack_q          <= ack_d;
      di_q           <= di_d;
      rd_q           <= rd_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      din_q          <= din_d;
      ptr_q          <= ptr_d;
      slot_q         <= slot_d;
      overflow_q     <= overflow_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_pending) state_d = ddr_wren ? StWrIssue : StRdIssue;
      end
      StWrIssue: begin
        if (!ddram_busy) state_d = StIdle;
      end
      StRdIssue: begin
        if (!ddram_busy) state_d = StRdWait;
      end
      StRdWait: begin
        if (ddram_dout_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and pointer bookkeeping.
  always_comb begin
    req_seen_d     = req_seen_q;
    ack_d          = ack_q;
    di_d           = di_q;
    rd_d           = rd_q;
    we_d           = we_q;
    addr_d         = addr_q;
    din_d          = din_q;
    ptr_d          = ptr_q;
    slot_d         = slot_q;
    overflow_d     = overflow_q;
    restart_pend_d = restart_pend_q;

    unique case (state_q)
      StIdle: begin
        if (restart_apply) begin
          restart_pend_d = 1'b0;
          ptr_d          = eff_ptr;
          slot_d         = eff_slot;
          overflow_d     = eff_overflow;
        end
        if (req_pending) begin
          req_seen_d = ddr_req;
          addr_d     = slot_addr(BASE_ADDR, DDRAM_AW'(eff_slot), DDRAM_AW'(eff_ptr),
                                 SLOT_SHIFT);
          if (ddr_wren) begin
            we_d  = 1'b1;
            din_d = ddr_do;
          end else begin
            rd_d = 1'b1;
          end
        end
      end
      StWrIssue: begin
        if (ss_start) restart_pend_d = 1'b1;
        if (!ddram_busy) begin
          we_d  = 1'b0;
          ack_d = ~ack_q;
          ptr_d = ptr_inc;
          if (ptr_wrap) overflow_d = 1'b1;
        end
      end
      StRdIssue: begin
        if (ss_start) restart_pend_d = 1'b1;
        if (!ddram_busy) rd_d = 1'b0;
      end
      StRdWait: begin
        if (ss_start) restart_pend_d = 1'b1;
        if (ddram_dout_ready) begin
          di_d  = ddram_dout;
          ack_d = ~ack_q;
          ptr_d = ptr_inc;
          if (ptr_wrap) overflow_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ddr_ack        = ack_q;
  assign ddr_di         = di_q;
  assign overflow       = overflow_q;
  assign ddram_burstcnt = BURST_1;
  assign ddram_be       = BE_ALL;
  assign ddram_addr     = addr_q;
  assign ddram_rd       = rd_q;
  assign ddram_we       = we_q;
  assign ddram_din      = din_q;

endmodule

// File: tb/tb_savestate_ddr_responder.sv
// Directed bench for savestate_ddr_responder: writes, reads with waitrequest,
// deferred restart, reset during a read, pointer wrap and port invariants.
module tb_savestate_ddr_responder;

  localparam logic [28:0] Base = 29'h0180_0000;

  logic        clk;
  logic        reset_n;
  logic        ss_start;
  logic [1:0]  ss_slot;
  logic        ddr_req;
  logic        ddr_wren;
  logic [63:0] ddr_do;
  logic [63:0] ddr_di;
  logic        ddr_ack;
  logic        overflow;
  logic        ddram_busy;
  logic [7:0]  ddram_burstcnt;
  logic [28:0] ddram_addr;
  logic        ddram_rd;
  logic        ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;

  int n_pass  = 0;
  int n_total = 0;
  int bad_both = 0;
  int bad_addr = 0;

  savestate_ddr_responder dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ss_start         (ss_start),
    .ss_slot          (ss_slot),
    .ddr_req          (ddr_req),
    .ddr_wren         (ddr_wren),
    .ddr_do           (ddr_do),
    .ddr_di           (ddr_di),
    .ddr_ack          (ddr_ack),
    .overflow         (overflow),
    .ddram_busy       (ddram_busy),
    .ddram_burstcnt   (ddram_burstcnt),
    .ddram_addr       (ddram_addr),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port invariants watched for the whole run.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ddram_we && ddram_rd) bad_both++;
      if ((ddram_we || ddram_rd) &&
          ((ddram_addr < Base) || (ddram_addr >= Base + 29'h2_0000))) bad_addr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ss_start = 1'b0; ss_slot = 2'd0; ddr_req = 1'b0; ddr_wren = 1'b0;
    ddr_do = '0; ddram_busy = 1'b0; ddram_dout = '0; ddram_dout_ready = 1'b0;
    tick(); tick();
    n_total++; if (ddr_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", ddr_ack);
    else n_pass++;
    n_total++; if (ddr_di !== 64'd0) $display("FAIL reset_di: got %h want 0", ddr_di);
    else n_pass++;
    n_total++; if ({ddram_rd, ddram_we} !== 2'b00)
      $display("FAIL reset_strobes: got %b want 00", {ddram_rd, ddram_we});
    else n_pass++;
    n_total++; if (ddram_addr !== Base) $display("FAIL reset_addr: got %h want %h", ddram_addr, Base);
    else n_pass++;
    n_total++; if (ddram_din !== 64'd0) $display("FAIL reset_din: got %h want 0", ddram_din);
    else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow);
    else n_pass++;
    n_total++; if ({ddram_burstcnt, ddram_be} !== {8'd1, 8'hFF})
      $display("FAIL const_ports: got %h want 01ff", {ddram_burstcnt, ddram_be});
    else n_pass++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_seq();
    logic [63:0] data [3];
    data[0] = 64'h1111_1111_1111_1111;
    data[1] = 64'h2222_2222_2222_2222;
    data[2] = 64'h3333_3333_3333_3333;
    ss_start = 1'b1; ss_slot = 2'd1;
    tick();
    ss_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ddr_req = ~ddr_req; ddr_wren = 1'b1; ddr_do = data[i];
      tick();
      n_total++; if (ddram_we !== 1'b1) $display("FAIL wr%0d_we: got %b want 1", i, ddram_we);
      else n_pass++;
      n_total++; if (ddram_addr !== Base + 29'h8000 + 29'(i))
        $display("FAIL wr%0d_addr: got %h want %h", i, ddram_addr, Base + 29'h8000 + 29'(i));
      else n_pass++;
      n_total++; if (ddram_din !== data[i])
        $display("FAIL wr%0d_din: got %h want %h", i, ddram_din, data[i]);
      else n_pass++;
      n_total++; if (ddr_ack !== ~ddr_req)
        $display("FAIL wr%0d_ack_early: got %b want %b", i, ddr_ack, ~ddr_req);
      else n_pass++;
      tick();
      n_total++; if ({ddram_we, ddr_ack} !== {1'b0, ddr_req})
        $display("FAIL wr%0d_done: got we,ack=%b want %b", i, {ddram_we, ddr_ack}, {1'b0, ddr_req});
      else n_pass++;
    end
  endtask

  task automatic test_read_wait();
    logic ack0;
    ss_start = 1'b1; ss_slot = 2'd0;
    tick();
    ss_start = 1'b0;
    ack0 = ddr_ack;
    ddr_req = ~ddr_req; ddr_wren = 1'b0; ddram_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) ddram_busy = 1'b0;
      n_total++; if ({ddram_rd, ddram_addr} !== {1'b1, Base})
        $display("FAIL rd_hold%0d: got rd=%b addr=%h want rd=1 addr=%h", i, ddram_rd,
                 ddram_addr, Base);
      else n_pass++;
    end
    tick();
    n_total++; if (ddram_rd !== 1'b0) $display("FAIL rd_release: got %b want 0", ddram_rd);
    else n_pass++;
    tick();
    n_total++; if ({ddr_ack, ddr_di} !== {ack0, 64'd0})
      $display("FAIL rd_not_yet: got ack=%b di=%h want ack=%b di=0", ddr_ack, ddr_di, ack0);
    else n_pass++;
    ddram_dout = 64'hDEAD_BEEF_CAFE_F00D; ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    n_total++; if ({ddr_ack, ddr_di} !== {~ack0, 64'hDEAD_BEEF_CAFE_F00D})
      $display("FAIL rd_data: got ack=%b di=%h want ack=%b di=deadbeefcafef00d", ddr_ack,
               ddr_di, ~ack0);
    else n_pass++;
    // Stale return in IDLE is ignored.
    ddram_dout = 64'h0123_4567_89AB_CDEF; ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    n_total++; if ({ddr_ack, ddr_di} !== {~ack0, 64'hDEAD_BEEF_CAFE_F00D})
      $display("FAIL stale_ready: got ack=%b di=%h want ack=%b di=deadbeefcafef00d", ddr_ack,
               ddr_di, ~ack0);
    else n_pass++;
  endtask

  task automatic test_deferred_restart();
    // Pointer is slot 0, word 1 after the previous read.
    ddr_req = ~ddr_req; ddr_wren = 1'b0;
    tick();
    n_total++; if (ddram_addr !== Base + 29'd1)
      $display("FAIL defer_rd_addr: got %h want %h", ddram_addr, Base + 29'd1);
    else n_pass++;
    tick();
    ss_start = 1'b1; ss_slot = 2'd2;
    tick();
    ss_start = 1'b0;
    n_total++; if (ddr_ack !== ~ddr_req)
      $display("FAIL defer_not_aborted: got ack=%b want %b", ddr_ack, ~ddr_req);
    else n_pass++;
    ddram_dout = 64'h5555_AAAA_5555_AAAA; ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    n_total++; if ({ddr_ack, ddr_di} !== {ddr_req, 64'h5555_AAAA_5555_AAAA})
      $display("FAIL defer_rd_done: got ack=%b di=%h", ddr_ack, ddr_di);
    else n_pass++;
    ddr_req = ~ddr_req; ddr_wren = 1'b1; ddr_do = 64'h77;
    tick();
    n_total++; if ({ddram_we, ddram_addr} !== {1'b1, Base + 29'h1_0000})
      $display("FAIL defer_next_addr: got we=%b addr=%h want we=1 addr=%h", ddram_we,
               ddram_addr, Base + 29'h1_0000);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_read();
    ddr_req = ~ddr_req; ddr_wren = 1'b0;
    tick(); tick();
    reset_n = 1'b0; ddr_req = 1'b0;
    tick();
    n_total++; if ({ddr_ack, ddram_rd, ddram_we, ddram_addr, ddr_di, overflow} !==
                   {1'b0, 1'b0, 1'b0, Base, 64'd0, 1'b0})
      $display("FAIL midrd_reset: got ack=%b rd=%b we=%b addr=%h di=%h", ddr_ack, ddram_rd,
               ddram_we, ddram_addr, ddr_di);
    else n_pass++;
    reset_n = 1'b1;
    ddram_dout = 64'hBAD0_BAD0_BAD0_BAD0; ddram_dout_ready = 1'b1;
    tick();
    ddram_dout_ready = 1'b0;
    tick();
    n_total++; if ({ddr_ack, ddram_rd, ddram_we, ddr_di} !== {1'b0, 1'b0, 1'b0, 64'd0})
      $display("FAIL late_ready: got ack=%b rd=%b we=%b di=%h want 0 0 0 0", ddr_ack,
               ddram_rd, ddram_we, ddr_di);
    else n_pass++;
    ddr_req = 1'b1; ddr_wren = 1'b1; ddr_do = 64'h99;
    tick();
    n_total++; if ({ddram_we, ddram_addr} !== {1'b1, Base})
      $display("FAIL post_reset_wr: got we=%b addr=%h want we=1 addr=%h", ddram_we,
               ddram_addr, Base);
    else n_pass++;
    tick();
    n_total++; if (ddr_ack !== 1'b1) $display("FAIL post_reset_ack: got %b want 1", ddr_ack);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int ack_err = 0;
    ss_start = 1'b1; ss_slot = 2'd3;
    tick();
    ss_start = 1'b0;
    for (int i = 0; i < 32769; i++) begin
      ddr_req = ~ddr_req; ddr_wren = 1'b1; ddr_do = 64'(i);
      tick();
      if (i == 32768) begin
        n_total++; if (ddram_addr !== Base + 29'h1_8000)
          $display("FAIL wrap_addr: got %h want %h", ddram_addr, Base + 29'h1_8000);
        else n_pass++;
      end
      tick();
      if (ddr_ack !== ddr_req) ack_err++;
      if (i == 32766) begin
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow);
        else n_pass++;
      end
      if (i == 32767) begin
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow);
        else n_pass++;
      end
    end
    n_total++; if (ack_err !== 0) $display("FAIL wrap_acks: got %0d late acks want 0", ack_err);
    else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow);
    else n_pass++;
    ss_start = 1'b1; ss_slot = 2'd0;
    tick();
    ss_start = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_invariants();
    n_total++; if (bad_both !== 0) $display("FAIL rd_we_both: got %0d cycles want 0", bad_both);
    else n_pass++;
    n_total++; if (bad_addr !== 0) $display("FAIL addr_range: got %0d cycles want 0", bad_addr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_read_wait();
    test_deferred_restart();
    test_reset_mid_read();
    test_wrap();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
